obb_bank_integrator: RTL and testbench
======================================

// Module: obb_bank_integrator
// PURPOSE
//  Multi-body successor to the single-OBB next-state logic: holds NUM_BODIES OBB states in a register bank.
//  Accumulates impulses per body between physics ticks, then on 'start' sweeps bodies one per cycle:
//  apply pending impulse -> integrate pos/angle -> wrap angle to [0,2pi) -> write back.
//  Sits between the contact/impulse solver (producer) and the renderer/collision stage (consumers of rd_*).
// PARAMETERS
//  NUM_BODIES  8        bodies in bank (>=1)
//  ID_W        3        $clog2(NUM_BODIES), min 1
//  ARENA_MAX   64       wall bound (integer units) for pos.x/pos.y, used only with OBB_WALL_BOUNCE_EN
// PORTS
//  Clk        in   1        system clock
//  Reset      in   1        synchronous, active-high
//  start      in   1        begin sweep (ignored while busy)
//  update_en  in   1        sampled at start: 1 = integrate pos/angle, 0 = impulses only
//  busy       out  1        sweep in progress
//  done       out  1        1-cycle pulse after last body written
//  ld_valid   in   1        load full state for ld_id (initialisation)
//  ld_id      in   ID_W     body index
//  ld_state   in   obb_t    state to load
//  imp_valid  in   1        impulse offered
//  imp_ready  out  1        = !busy && !Reset
//  imp_id     in   ID_W     target body
//  imp_dv     in   vel_vec_t      linear impulse (Q5.19 per axis)
//  imp_dw     in   omega_t        rotational impulse
//  imp_nudge  in   pos_vec_t      position correction (Q8.16 per axis)
//  rd_id      in   ID_W     read select
//  rd_state   out  obb_t    registered: state of rd_id, valid 1 cycle after rd_id
// BEHAVIOUR
//  Reset: all bodies, pending accumulators, rd_state = 0; busy=0, done=0; FSM -> IDLE. Reset mid-sweep aborts, no done.
//  FSM: IDLE --start&&!ld_valid--> SWEEP(idx=0) ; SWEEP idx++ each cycle ; idx==NUM_BODIES-1 -> DONE ; DONE -> IDLE (done=1 here).
//   Latency start->done = NUM_BODIES+1 cycles; busy high in SWEEP and DONE.
//  Impulse accept (imp_valid&&imp_ready): pend[imp_id] += imp_dv/imp_dw/imp_nudge, two's-complement wrap,
//   same widths as fields. Multiple impulses to one body per tick sum.
//  Per body in SWEEP (combinational on bank[idx], written at cycle end):
//   v' = v + pend.dv ; w' = w + pend.dw ; p' = p + pend.nudge ; pend[idx] cleared.
//   if update_en_q: p'' = p' + v' (vel resized Q5.19 -> Q8.16, sign-extended, truncated) ; a = angle + w'.
//   Angle wrap: a >= TWO_PI -> a - TWO_PI ; a < 0 -> a + TWO_PI ; single correction only (|w| < 2pi required).
//   width/height/inv_mass/inertia/inv_inertia pass through unchanged.
//  ld_valid: writes bank[ld_id], clears pend[ld_id]; IDLE only (ignored while busy); ld beats start same cycle.
//  Impulse and ld same id same cycle: ld wins, impulse dropped (still handshaken).
//  ids >= NUM_BODIES on ld/imp/rd: write ignored, read returns 0.
// CONFIGURATION
//  OBB_WALL_BOUNCE_EN defined: after impulse step, if pre-update p.x<0 or p.x>ARENA_MAX, v'.x negated; same for y.
//   Negated velocity is the one written back and used for integration.
//  Undefined: no wall logic, velocities pass unchanged; ARENA_MAX unused.
// STRUCTURE
//  Package obb_pkg: fixed-point widths (POS Q8.16, VEL Q5.19, ANGLE Q4.7 -> 11b signed),
//   TWO_PI constant, typedefs pos_vec_t, vel_vec_t, omega_t, angle_t, obb_t, pend_t.
//  Sub-module obb_step (combinational): one body's impulse+bounce+integrate+wrap; bank/FSM/accumulators in top.
// TESTING
//  1 Reset mid-sweep (after 3 cycles of SWEEP) -> busy=0 next cycle, no done, all rd_state=0.
//  2 ld body2 pos=(10,10) v=(1,0) w=0; start update_en=1 -> done at cycle NUM_BODIES+1; rd body2 pos=(11,10).
//  3 Two impulses dv=(0.5,0) to body0 then start update_en=0 -> v=(1.0,0), pos unchanged, pend cleared (2nd tick no change).
//  4 angle=6.2, w=0.2, update_en=1 -> angle ~0.117 (6.4-2pi, LSB 1/128); angle=0.05, w=-0.1 -> ~6.233.
//  5 imp_valid held during sweep -> imp_ready=0 throughout, accepted first IDLE cycle; same-cycle ld+imp same id -> ld state only.
//  6 OBB_WALL_BOUNCE_EN: pos.x=65, v.x=+1 -> v.x=-1, pos.x=64; without macro -> pos.x=66.

Source files
------------

// File: rtl/obb_pkg.sv
// Fixed-point formats, body/pending record types and sweep FSM states shared
// by the OBB bank integrator and its per-body step logic.
//   POS   Q8.16  (24b signed)
//   VEL   Q5.19  (24b signed)
//   ANGLE Q4.7   (11b signed), omega uses the same format
package obb_pkg;

  localparam int POS_W    = 24;
  localparam int POS_FRAC = 16;
  localparam int VEL_W    = 24;
  localparam int VEL_FRAC = 19;
  localparam int ANG_W    = 11;
  localparam int ANG_FRAC = 7;
  localparam int SCAL_W   = 16;

  // Q5.19 -> Q8.16 is an arithmetic right shift by the fraction difference
  localparam int VEL_TO_POS_SHIFT = VEL_FRAC - POS_FRAC;

  // 2*pi in Q4.7 (round(6.2832 * 128) = 804), one bit wider than the angle
  localparam logic signed [ANG_W:0] TWO_PI = 12'sd804;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [ANG_W-1:0] angle_t;
  typedef logic signed [ANG_W-1:0] omega_t;
  typedef logic [SCAL_W-1:0]       scal_t;

  typedef struct packed {
    pos_t x;
    pos_t y;
  } pos_vec_t;

  typedef struct packed {
    vel_t x;
    vel_t y;
  } vel_vec_t;

  typedef struct packed {
    pos_vec_t pos;
    vel_vec_t vel;
    omega_t   omega;
    angle_t   angle;
    scal_t    width;
    scal_t    height;
    scal_t    inv_mass;
    scal_t    inertia;
    scal_t    inv_inertia;
  } obb_t;

  typedef struct packed {
    vel_vec_t dv;
    omega_t   dw;
    pos_vec_t nudge;
  } pend_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } sweep_state_e;

  // Accumulate one impulse into a pending record (two's-complement wrap)
  function automatic pend_t pend_add(pend_t p, vel_vec_t dv, omega_t dw, pos_vec_t nudge);
    pend_t r;
    r.dv.x    = p.dv.x + dv.x;
    r.dv.y    = p.dv.y + dv.y;
    r.dw      = p.dw + dw;
    r.nudge.x = p.nudge.x + nudge.x;
    r.nudge.y = p.nudge.y + nudge.y;
    return r;
  endfunction

endpackage

// File: rtl/obb_step.sv
// Combinational next-state for one body: apply pending impulse, optional wall
// bounce, optional integration of position/angle, angle wrap into [0, 2pi).
// Wall bounce is built only when OBB_WALL_BOUNCE_EN is defined.
module obb_step
  import obb_pkg::*;
#(
  parameter int ARENA_MAX = 64
) (
  input  obb_t  i_body,
  input  pend_t i_pend,
  input  logic  i_update,
  output obb_t  o_body
);

  localparam pos_t ARENA_LIM = pos_t'(ARENA_MAX * (1 << POS_FRAC));

  logic                   w_bounce_en;
  vel_t                   w_vx;
  vel_t                   w_vy;
  pos_t                   w_px;
  pos_t                   w_py;
  omega_t                 w_w;
  logic signed [ANG_W:0]  w_asum;
  logic signed [ANG_W:0]  w_awrap;

`ifdef OBB_WALL_BOUNCE_EN
  assign w_bounce_en = 1'b1;
`else
  assign w_bounce_en = 1'b0;
`endif

  // Impulse, bounce, integrate and wrap for the body being swept
  always_comb begin
    w_vx = i_body.vel.x + i_pend.dv.x;
    w_vy = i_body.vel.y + i_pend.dv.y;
    w_w  = i_body.omega + i_pend.dw;
    w_px = i_body.pos.x + i_pend.nudge.x;
    w_py = i_body.pos.y + i_pend.nudge.y;

    if (w_bounce_en && (w_px[POS_W-1] || (w_px > ARENA_LIM))) w_vx = -w_vx;
    if (w_bounce_en && (w_py[POS_W-1] || (w_py > ARENA_LIM))) w_vy = -w_vy;

    // Sum one bit wider so angle + omega cannot overflow before the wrap
    w_asum  = $signed({i_body.angle[ANG_W-1], i_body.angle}) + $signed({w_w[ANG_W-1], w_w});
    w_awrap = w_asum;
    if (w_asum >= TWO_PI)   w_awrap = w_asum - TWO_PI;
    else if (w_asum[ANG_W]) w_awrap = w_asum + TWO_PI;

    o_body       = i_body;
    o_body.vel.x = w_vx;
    o_body.vel.y = w_vy;
    o_body.omega = w_w;
    o_body.pos.x = w_px;
    o_body.pos.y = w_py;
    if (i_update) begin
      o_body.pos.x = w_px + pos_t'(w_vx >>> VEL_TO_POS_SHIFT);
      o_body.pos.y = w_py + pos_t'(w_vy >>> VEL_TO_POS_SHIFT);
      o_body.angle = w_awrap[ANG_W-1:0];
    end
  end

endmodule

// File: rtl/obb_bank_integrator.sv
// Register bank of NUM_BODIES OBB states with per-body impulse accumulators.
// On start, sweeps one body per cycle through obb_step and writes it back.
// Optional feature macro: OBB_WALL_BOUNCE_EN (wall bounce inside obb_step).
module obb_bank_integrator
  import obb_pkg::*;
#(
  parameter int NUM_BODIES = 8,
  parameter int ID_W       = 3,
  parameter int ARENA_MAX  = 64
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            start,
  input  logic            update_en,
  output logic            busy,
  output logic            done,
  input  logic            ld_valid,
  input  logic [ID_W-1:0] ld_id,
  input  obb_t            ld_state,
  input  logic            imp_valid,
  output logic            imp_ready,
  input  logic [ID_W-1:0] imp_id,
  input  vel_vec_t        imp_dv,
  input  omega_t          imp_dw,
  input  pos_vec_t        imp_nudge,
  input  logic [ID_W-1:0] rd_id,
  output obb_t            rd_state
);

  sweep_state_e    r_state;
  sweep_state_e    w_state_nxt;
  logic [ID_W-1:0] r_idx;
  logic [ID_W-1:0] w_idx_nxt;
  logic            r_update_q;
  obb_t            r_bank [NUM_BODIES];
  pend_t           r_pend [NUM_BODIES];
  obb_t            r_rd_state;
  obb_t            w_step_out;

  logic w_idle;
  logic w_go;
  logic w_last;
  logic w_ld_ok;
  logic w_imp_acc;
  logic w_rd_ok;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_go    = w_idle && start && !ld_valid;
  assign w_last  = (32'(r_idx) == 32'(NUM_BODIES - 1));
  assign w_ld_ok = w_idle && ld_valid && (32'(ld_id) < 32'(NUM_BODIES));
  assign w_rd_ok = (32'(rd_id) < 32'(NUM_BODIES));

  assign imp_ready = !busy && !Reset;
  // A load to the same body in the same cycle overrides the impulse
  assign w_imp_acc = imp_valid && imp_ready && (32'(imp_id) < 32'(NUM_BODIES))
                     && !(w_ld_ok && (ld_id == imp_id));

  assign rd_state = r_rd_state;

  obb_step #(
    .ARENA_MAX(ARENA_MAX)
  ) u_step (
    .i_body  (r_bank[r_idx]),
    .i_pend  (r_pend[r_idx]),
    .i_update(r_update_q),
    .o_body  (w_step_out)
  );

  // Sweep FSM state, body index and latched integrate mode
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_update_q <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_go) r_update_q <= update_en;
    end
  end

  // Next-state, index advance, busy/done decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_go) begin
          w_state_nxt = ST_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_idx_nxt   = r_idx + 1'b1;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Body bank and pending accumulators: sweep write-back, impulse add, load
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_BODIES; i++) begin
        r_bank[i] <= '0;
        r_pend[i] <= '0;
      end
    end else begin
      if (r_state == ST_SWEEP) begin
        r_bank[r_idx] <= w_step_out;
        r_pend[r_idx] <= '0;
      end
      if (w_imp_acc) r_pend[imp_id] <= pend_add(r_pend[imp_id], imp_dv, imp_dw, imp_nudge);
      if (w_ld_ok) begin
        r_bank[ld_id] <= ld_state;
        r_pend[ld_id] <= '0;
      end
    end
  end

  // Registered read port
  always_ff @(posedge Clk) begin
    if (Reset)        r_rd_state <= '0;
    else if (w_rd_ok) r_rd_state <= r_bank[rd_id];
    else              r_rd_state <= '0;
  end

endmodule

// File: tb/tb_obb_bank_integrator.sv
// Directed bench for obb_bank_integrator. A plain-integer model of the body
// bank tracks loads, impulses and whole-tick updates; a negedge process
// compares busy/done/imp_ready every cycle and rd_state during scans.
module tb_obb_bank_integrator;
  import obb_pkg::*;

  localparam int NB    = 8;
  localparam int IDW   = 3;
  localparam int ARENA = 64;
  localparam int ONE_P = 1 << 16;
  localparam int ONE_V = 1 << 19;

  logic           Clk = 1'b0;
  logic           Reset, start, update_en, busy, done;
  logic           ld_valid, imp_valid, imp_ready;
  logic [IDW-1:0] ld_id, imp_id, rd_id;
  obb_t           ld_state, rd_state;
  vel_vec_t       imp_dv;
  omega_t         imp_dw;
  pos_vec_t       imp_nudge;
  logic           scan_on;

  int errs   = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  obb_bank_integrator #(
    .NUM_BODIES(NB),
    .ID_W      (IDW),
    .ARENA_MAX (ARENA)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .update_en(update_en),
    .busy(busy), .done(done),
    .ld_valid(ld_valid), .ld_id(ld_id), .ld_state(ld_state),
    .imp_valid(imp_valid), .imp_ready(imp_ready), .imp_id(imp_id),
    .imp_dv(imp_dv), .imp_dw(imp_dw), .imp_nudge(imp_nudge),
    .rd_id(rd_id), .rd_state(rd_state)
  );

  // ---------------- model ----------------
  int          mpx[NB], mpy[NB], mvx[NB], mvy[NB], mw[NB], ma[NB];
  logic [79:0] mrest[NB];
  int          pvx[NB], pvy[NB], pw[NB], pnx[NB], pny[NB];
  int          m_cnt = 0;
  logic [IDW-1:0] rd_id_s;
  logic        scan_s = 1'b0;

  function automatic int wrap(input int v, input int n);
    int t;
    t = v <<< (32 - n);
    return t >>> (32 - n);
  endfunction

  function automatic obb_t mk(input int px, input int py, input int vx, input int vy,
                              input int w, input int a, input logic [15:0] tag);
    obb_t o;
    o.pos.x = pos_t'(px);  o.pos.y = pos_t'(py);
    o.vel.x = vel_t'(vx);  o.vel.y = vel_t'(vy);
    o.omega = omega_t'(w); o.angle = angle_t'(a);
    o.width = tag; o.height = tag + 16'd1; o.inv_mass = tag + 16'd2;
    o.inertia = tag + 16'd3; o.inv_inertia = tag + 16'd4;
    return o;
  endfunction

  function automatic obb_t model_obb(input int i);
    obb_t o;
    o.pos.x = pos_t'(mpx[i]); o.pos.y = pos_t'(mpy[i]);
    o.vel.x = vel_t'(mvx[i]); o.vel.y = vel_t'(mvy[i]);
    o.omega = omega_t'(mw[i]); o.angle = angle_t'(ma[i]);
    {o.width, o.height, o.inv_mass, o.inertia, o.inv_inertia} = mrest[i];
    return o;
  endfunction

  task automatic m_clear_pend(input int i);
    pvx[i] = 0; pvy[i] = 0; pw[i] = 0; pnx[i] = 0; pny[i] = 0;
  endtask

  // One physics tick over every body, applied all at once
  task automatic m_tick(input bit upd);
    for (int i = 0; i < NB; i++) begin
      int vx, vy, w, px, py, a;
      vx = wrap(mvx[i] + pvx[i], 24);
      vy = wrap(mvy[i] + pvy[i], 24);
      w  = wrap(mw[i] + pw[i], 11);
      px = wrap(mpx[i] + pnx[i], 24);
      py = wrap(mpy[i] + pny[i], 24);
`ifdef OBB_WALL_BOUNCE_EN
      if (px < 0 || px > ARENA * ONE_P) vx = wrap(-vx, 24);
      if (py < 0 || py > ARENA * ONE_P) vy = wrap(-vy, 24);
`endif
      if (upd) begin
        px = wrap(px + (vx >>> 3), 24);
        py = wrap(py + (vy >>> 3), 24);
        a  = ma[i] + w;
        if (a >= 804)   a = a - 804;
        else if (a < 0) a = a + 804;
        ma[i] = wrap(a, 11);
      end
      mvx[i] = vx; mvy[i] = vy; mw[i] = w; mpx[i] = px; mpy[i] = py;
      m_clear_pend(i);
    end
  endtask

  // Model update on each rising edge from the driven inputs
  initial forever begin
    bit idle;
    @(posedge Clk);
    if (Reset) begin
      m_cnt = 0;
      for (int i = 0; i < NB; i++) begin
        mpx[i] = 0; mpy[i] = 0; mvx[i] = 0; mvy[i] = 0; mw[i] = 0; ma[i] = 0;
        mrest[i] = '0;
        m_clear_pend(i);
      end
    end else begin
      idle = (m_cnt == 0);
      if (m_cnt > 0) m_cnt--;
      if (idle) begin
        if (imp_valid && !(ld_valid && ld_id == imp_id)) begin
          pvx[imp_id] = wrap(pvx[imp_id] + int'(imp_dv.x), 24);
          pvy[imp_id] = wrap(pvy[imp_id] + int'(imp_dv.y), 24);
          pw[imp_id]  = wrap(pw[imp_id] + int'(imp_dw), 11);
          pnx[imp_id] = wrap(pnx[imp_id] + int'(imp_nudge.x), 24);
          pny[imp_id] = wrap(pny[imp_id] + int'(imp_nudge.y), 24);
        end
        if (ld_valid) begin
          mpx[ld_id] = int'(ld_state.pos.x); mpy[ld_id] = int'(ld_state.pos.y);
          mvx[ld_id] = int'(ld_state.vel.x); mvy[ld_id] = int'(ld_state.vel.y);
          mw[ld_id]  = int'(ld_state.omega); ma[ld_id]  = int'(ld_state.angle);
          mrest[ld_id] = {ld_state.width, ld_state.height, ld_state.inv_mass,
                          ld_state.inertia, ld_state.inv_inertia};
          m_clear_pend(int'(ld_id));
        end else if (start) begin
          m_tick(update_en);
          m_cnt = NB + 1;
        end
      end
    end
    rd_id_s = rd_id;
    scan_s  = scan_on;
  end

  // ---------------- checking ----------------
  task automatic check_int(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_obb(input string nm, input obb_t got, input obb_t exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge Clk);
    check_int("busy", int'(busy), int'(m_cnt > 0));
    check_int("done", int'(done), int'(m_cnt == 1));
    check_int("imp_ready", int'(imp_ready), int'(m_cnt == 0 && !Reset));
    if (scan_s) check_obb("rd_state", rd_state, model_obb(int'(rd_id_s)));
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input int id, input obb_t s);
    @(posedge Clk); #1;
    ld_valid = 1'b1; ld_id = IDW'(id); ld_state = s;
    @(posedge Clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic impulse(input int id, input int dvx, input int dvy);
    @(posedge Clk); #1;
    imp_valid = 1'b1; imp_id = IDW'(id);
    imp_dv.x = vel_t'(dvx); imp_dv.y = vel_t'(dvy);
    @(posedge Clk); #1;
    imp_valid = 1'b0; imp_dv = '0;
  endtask

  task automatic run_tick(input logic upd);
    int lat;
    @(posedge Clk); #1;
    start = 1'b1; update_en = upd;
    lat = -1;
    for (int n = 1; n <= 4 * NB; n++) begin
      @(posedge Clk);
      if (n == 1) begin #1; start = 1'b0; end
      @(negedge Clk);
      if (done) begin lat = n; break; end
    end
    check_int("tick_latency", lat, NB + 1);
  endtask

  task automatic peek(input int id, output obb_t o);
    @(posedge Clk); #1;
    rd_id = IDW'(id);
    @(posedge Clk);
    @(negedge Clk);
    o = rd_state;
  endtask

  task automatic scan();
    @(posedge Clk); #1;
    scan_on = 1'b1;
    for (int id = 0; id < NB; id++) begin
      rd_id = IDW'(id);
      @(posedge Clk); #1;
    end
    scan_on = 1'b0;
    @(posedge Clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    obb_t o;
    int   wait_n;
    Reset = 1'b1; start = 1'b0; update_en = 1'b0;
    ld_valid = 1'b0; ld_id = '0; ld_state = '0;
    imp_valid = 1'b0; imp_id = '0; imp_dv = '0; imp_dw = '0; imp_nudge = '0;
    rd_id = '0; scan_on = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    scan();

    // Reset in the third sweep cycle aborts the tick and clears the bank
    load(2, mk(10 * ONE_P, 10 * ONE_P, ONE_V, 0, 0, 0, 16'h0100));
    @(posedge Clk); #1 start = 1'b1; update_en = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    scan();
    peek(2, o);
    check_obb("reset_clears_body2", o, '0);

    // Integration of a single moving body
    load(2, mk(10 * ONE_P, 10 * ONE_P, ONE_V, 0, 0, 0, 16'h0200));
    run_tick(1'b1);
    peek(2, o);
    check_int("body2_pos_x", int'(o.pos.x), 11 * ONE_P);
    check_int("body2_pos_y", int'(o.pos.y), 10 * ONE_P);
    check_int("body2_width", int'(o.width), 32'h0200);

    // Two impulses sum; impulse-only tick leaves position; pending is cleared
    impulse(0, ONE_V / 2, 0);
    impulse(0, ONE_V / 2, 0);
    run_tick(1'b0);
    peek(0, o);
    check_int("body0_vel_x", int'(o.vel.x), ONE_V);
    check_int("body0_pos_x", int'(o.pos.x), 0);
    run_tick(1'b0);
    peek(0, o);
    check_int("body0_vel_x_2nd", int'(o.vel.x), ONE_V);
    scan();

    // Angle wrap both directions
    load(3, mk(0, 0, 0, 0, 26, 794, 16'h0300));
    load(4, mk(0, 0, 0, 0, -13, 6, 16'h0400));
    run_tick(1'b1);
    peek(3, o);
    check_int("body3_angle_wrap_hi", int'(o.angle), 16);
    peek(4, o);
    check_int("body4_angle_wrap_lo", int'(o.angle), 797);
    scan();

    // Impulse held across a sweep is accepted on the first idle cycle
    @(posedge Clk); #1 start = 1'b1; update_en = 1'b0;
    @(posedge Clk); #1 start = 1'b0;
    imp_valid = 1'b1; imp_id = 3'd5; imp_dv.x = '0; imp_dv.y = vel_t'(3);
    wait_n = 0;
    while (!done && wait_n < 4 * NB) begin
      @(negedge Clk);
      wait_n++;
    end
    check_int("held_imp_done_seen", int'(done), 1);
    @(posedge Clk); #1;
    @(posedge Clk); #1 imp_valid = 1'b0; imp_dv = '0;
    run_tick(1'b0);
    peek(5, o);
    check_int("body5_vel_y", int'(o.vel.y), 3);

    // Same-cycle load and impulse to one body: load wins
    @(posedge Clk); #1;
    ld_valid = 1'b1; ld_id = 3'd6; ld_state = mk(ONE_P, ONE_P, 2 * ONE_V, 0, 0, 0, 16'h0600);
    imp_valid = 1'b1; imp_id = 3'd6; imp_dv.x = vel_t'(100); imp_dv.y = '0;
    @(posedge Clk); #1;
    ld_valid = 1'b0; imp_valid = 1'b0; imp_dv = '0;
    run_tick(1'b0);
    peek(6, o);
    check_int("body6_ld_wins_vel_x", int'(o.vel.x), 2 * ONE_V);
    scan();

    // Body beyond the +x wall
    load(7, mk(65 * ONE_P, 0, ONE_V, 0, 0, 0, 16'h0700));
    run_tick(1'b1);
    peek(7, o);
`ifdef OBB_WALL_BOUNCE_EN
    check_int("body7_pos_x", int'(o.pos.x), 64 * ONE_P);
    check_int("body7_vel_x", int'(o.vel.x), -ONE_V);
`else
    check_int("body7_pos_x", int'(o.pos.x), 66 * ONE_P);
    check_int("body7_vel_x", int'(o.vel.x), ONE_V);
`endif
    scan();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
